// File: rtl/pcie_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_mon_pkg
// Purpose  : Shared constants for the PCIe link monitor. Includes the link
//            state encoding that software reads, and the LED bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package pcie_mon_pkg;

    // Link state encoding, also visible to software through link_state
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_TRAIN = 2'd1;
    localparam logic [1:0] ST_UP    = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

    typedef enum logic [1:0] {
        S_RESET = ST_RESET,
        S_TRAIN = ST_TRAIN,
        S_UP    = ST_UP,
        S_FAIL  = ST_FAIL
    } link_state_e;

    // LED bit positions
    localparam int c_led_hb       = 0;
    localparam int c_led_link     = 1;
    localparam int c_led_train    = 2;
    localparam int c_led_timeout  = 3;
    localparam int c_led_perst    = 4;
    localparam int c_led_drop_lsb = 5;

endpackage : pcie_mon_pkg
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Purpose  : Two-flop synchroniser followed by a debounce filter. The filtered
//            output flips only after the synchronised input has disagreed with
//            it for DEBOUNCE_CYCLES consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic q_db
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_db;
    logic [c_cnt_w-1:0] r_cnt;

    // Two-flop synchroniser; resets to 0 so the input reads as deasserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_async;
            r_sync <= r_meta;
        end
    end

    // Debounce: count consecutive disagreement, flip once it has lasted long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_db  <= r_sync;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign q_sync = r_sync;
    assign q_db   = r_db;

endmodule : sync_debounce
`default_nettype wire

// File: rtl/pcie_link_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pcie_link_monitor
// Purpose  : Watches PERST# and link-up from the PCIe core. It tracks link
//            training, times it against a timeout, counts link drops, drives
//            a heartbeat and drives the board LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_link_monitor
    import pcie_mon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned TIMEOUT_CYCLES  = 25000000,
    parameter int unsigned HB_HALF_CYCLES  = 125000000,
    parameter int unsigned DROP_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcie_perst_n,
    input  logic              pcie_link_up,
    input  logic              clr,
    output logic [7:0]        LED,
    output logic [1:0]        link_state,
    output logic              timeout_flag,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [31:0]       train_cycles
);

    localparam logic [31:0] c_train_last = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_train_max  = 32'(TIMEOUT_CYCLES);
    localparam int          c_hb_w       = (HB_HALF_CYCLES > 1) ? $clog2(HB_HALF_CYCLES) : 1;
    localparam logic [c_hb_w-1:0] c_hb_last = c_hb_w'(HB_HALF_CYCLES - 1);

    logic              r_perst_meta;
    logic              r_perst_s;
    logic              w_link_db;
    link_state_e       r_state;
    link_state_e       w_state_nxt;
    logic [31:0]       r_train_cnt;
    logic [31:0]       w_train_cnt_nxt;
    logic              w_latch_train;
    logic              w_set_timeout;
    logic              w_drop_inc;
    logic              r_timeout;
    logic [DROP_W-1:0] r_drop;
    logic [31:0]       r_train_cycles;
    logic [c_hb_w-1:0] r_hb_cnt;
    logic              r_hb;
    logic [7:0]        r_led;

    // PERST# is level-only, so a bare synchroniser is enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perst_meta <= 1'b0;
            r_perst_s    <= 1'b0;
        end else begin
            r_perst_meta <= pcie_perst_n;
            r_perst_s    <= r_perst_meta;
        end
    end

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_link_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (pcie_link_up),
        .q_sync  (),
        .q_db    (w_link_db)
    );

    // Link state register and training counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_train_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_train_cnt <= w_train_cnt_nxt;
        end
    end

    // Next-state logic and the statistic update strobes
    always_comb begin
        w_state_nxt     = r_state;
        w_train_cnt_nxt = r_train_cnt;
        w_latch_train   = 1'b0;
        w_set_timeout   = 1'b0;
        w_drop_inc      = 1'b0;
        case (r_state)
            S_RESET: begin
                w_state_nxt     = S_TRAIN;
                w_train_cnt_nxt = '0;
            end
            S_TRAIN: begin
                if (r_train_cnt != c_train_max)
                    w_train_cnt_nxt = r_train_cnt + 32'd1;
                // Link-up takes priority over a coincident timeout
                if (w_link_db) begin
                    w_state_nxt   = S_UP;
                    w_latch_train = 1'b1;
                end else if (r_train_cnt == c_train_last) begin
                    w_state_nxt   = S_FAIL;
                    w_set_timeout = 1'b1;
                end
            end
            S_UP: begin
                if (!w_link_db) begin
                    w_state_nxt     = S_TRAIN;
                    w_train_cnt_nxt = '0;
                    w_drop_inc      = 1'b1;
                end
            end
            S_FAIL: begin
                if (w_link_db)
                    w_state_nxt = S_UP;
            end
            default: w_state_nxt = S_RESET;
        endcase
        // PERST# asserted overrides everything, link status is ignored
        if (!r_perst_s) begin
            w_state_nxt   = S_RESET;
            w_latch_train = 1'b0;
            w_set_timeout = 1'b0;
            w_drop_inc    = 1'b0;
        end
    end

    // Statistics; clr beats any coincident update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout      <= 1'b0;
            r_drop         <= '0;
            r_train_cycles <= '0;
        end else if (clr) begin
            r_timeout      <= 1'b0;
            r_drop         <= '0;
            r_train_cycles <= '0;
        end else begin
            if (w_set_timeout)
                r_timeout <= 1'b1;
            if (w_drop_inc && (r_drop != {DROP_W{1'b1}}))
                r_drop <= r_drop + 1'b1;
            if (w_latch_train)
                r_train_cycles <= r_train_cnt;
        end
    end

    // Free-running heartbeat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else if (r_hb_cnt == c_hb_last) begin
            r_hb_cnt <= '0;
            r_hb     <= ~r_hb;
        end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    // LED register samples the current status each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led[c_led_hb]                      <= r_hb;
            r_led[c_led_link]                    <= w_link_db;
            r_led[c_led_train]                   <= (r_state == S_TRAIN);
            r_led[c_led_timeout]                 <= r_timeout;
            r_led[c_led_perst]                   <= r_perst_s;
            r_led[c_led_drop_lsb +: 3]           <= r_drop[2:0];
        end
    end

    assign LED          = r_led;
    assign link_state   = r_state;
    assign timeout_flag = r_timeout;
    assign drop_cnt     = r_drop;
    assign train_cycles = r_train_cycles;

endmodule : pcie_link_monitor
`default_nettype wire
